simon_btn_conditioner: RTL
==========================

# simon_btn_conditioner

Input conditioner for the four game buttons, placed directly upstream of the Simon game state machine. Synchronises and debounces Btn_U/R/D/L and tracks each press. Each clean single-button press produces one single-cycle press event carrying the colour code the game compares against: 1=red/U, 2=blue/R, 3=yellow/D, 4=green/L. The game state machine then sees exactly one event per physical press and never sees bounce, chords or held buttons.

## Interface
- DB_CYCLES, default 16: consecutive cycles a synchronised input must differ from its debounced level before that level flips; legal range 2..65535.
- CW, default 16: debounce counter width; must satisfy 2^CW > DB_CYCLES.
- Clk  input  1  system clock, all logic on rising edge.
- Reset_n  input  1  reset. One clock; reset is asynchronous and active-low.
- Btn_U, Btn_R, Btn_D, Btn_L  input  1 each  raw asynchronous push-buttons, active-high.
- Clear  input  1  synchronous flush from the game SM, asserted on entry to U_INPUT or INITIAL.
- press_pulse  output  1  one-cycle strobe: a valid single-button press was accepted.
- press_code  output  3  code of the last accepted press: 1..4. Holds its value between strobes; 0 after reset or Clear.
- multi_err  output  1  one-cycle strobe: a press began with two or more buttons debounced-high together.
- btn_level  output  4  debounced levels {L,D,R,U}, bit 0 = U.
- any_held  output  1  OR of btn_level.

## Operation
- Synchroniser: two flops per button, cleared by reset. sync2 is the synchronised value.
- Debounce, per button: a CW-bit counter and a stable bit.
  - When sync2 == stable: counter clears to 0.
  - When sync2 != stable and counter == DB_CYCLES-1: stable <= sync2 and counter <= 0.
  - Otherwise, with sync2 != stable: counter increments.
  - A pulse shorter than DB_CYCLES cycles never changes stable.
  - The counter never wraps.
- btn_level = stable bits, registered. any_held = |btn_level.
- Press FSM, states IDLE and HELD:
  - IDLE, btn_level == 0: stay.
  - IDLE, btn_level nonzero and one-hot: register press_pulse=1 and press_code=encoded bit; go HELD.
  - IDLE, btn_level has two or more bits set: multi_err=1, press_code unchanged, no press_pulse; go HELD.
  - HELD: all other buttons pressed or released are ignored. Return to IDLE only on the cycle btn_level == 0 is seen.
  - Releasing a button and re-pressing the same button produces a new event only after btn_level has been fully 0 for at least one cycle.
- Clear (synchronous, priority over FSM transitions):
  - press_code <= 0; press_pulse and multi_err forced 0 that cycle.
  - State <= HELD if any_held, else IDLE, so a button already held at Clear does not generate a press.
  - Synchroniser and debounce state are not affected.
- Reset_n low, asynchronous, any time including mid-debounce or in HELD:
  - All flops to 0 and FSM to IDLE.
  - press_pulse=0, multi_err=0, press_code=0, btn_level=0, any_held=0.
  - After release, a button held through reset is debounced afresh and produces one press.

## Timing
- Raw button first sampled high at edge 0 and held:
  - sync2 = 1 after edge 1.
  - stable = 1 after edge DB_CYCLES+1.
  - btn_level = 1 after edge DB_CYCLES+2.
  - press_pulse high for exactly the cycle after edge DB_CYCLES+3.
- Release has the same latency to btn_level = 0. FSM is back in IDLE one edge later.
- press_code changes on the same edge press_pulse rises and is stable while press_pulse is high.
- press_pulse and multi_err are never high together and never high for two consecutive cycles.
- Minimum spacing between two press_pulses is 2*DB_CYCLES+6 cycles: press, full release, press.

## Test plan
- Single press, DB_CYCLES=4: Btn_U high from edge 0 for 20 cycles → press_pulse high only after edge 7, press_code=1, one pulse total. btn_level returns to 0 after edge 26 when released at edge 20.
- Bounce: Btn_R toggles 1,0,1,0 each cycle for 6 cycles, then held high → exactly one press_pulse with code 2, no multi_err. A 3-cycle glitch alone produces nothing.
- Chord: Btn_D and Btn_L rise on the same edge → one multi_err pulse, no press_pulse, press_code keeps its previous value. Both released, then Btn_L alone pressed → press_pulse, code 4.
- Overlap: Btn_U held, then Btn_D pressed while U still held → only the code-1 event; no event for D until both are released and D is pressed again.
- Clear while held: Btn_R held past its press_pulse, Clear pulsed → press_code=0, no new pulse while R stays held. Release then re-press R → code 2.
- Async reset: Reset_n pulsed low mid-debounce and mid-HELD, between clock edges → all outputs 0 immediately. With the button still held after reset release, exactly one press_pulse DB_CYCLES+3 edges later.

Source files
------------

// File: rtl/simon_btn_conditioner.sv
// ============================================================================
//  Module   : simon_btn_conditioner
//  Purpose  : Synchronise, debounce and press-track the four Simon buttons,
//             emitting one colour-coded strobe per clean single-button press.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module simon_btn_conditioner #(
    parameter int DB_CYCLES = 16,
    parameter int CW        = 16
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       Btn_U,
    input  logic       Btn_R,
    input  logic       Btn_D,
    input  logic       Btn_L,
    input  logic       Clear,
    output logic       press_pulse,
    output logic [2:0] press_code,
    output logic       multi_err,
    output logic [3:0] btn_level,
    output logic       any_held
);

    localparam logic [CW-1:0] C_DB_LAST = CW'(DB_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HELD = 1'b1
    } state_t;

    logic [3:0] w_btn_raw;
    logic [3:0] w_stable;

    assign w_btn_raw = {Btn_L, Btn_D, Btn_R, Btn_U};

    generate
        for (genvar i = 0; i < 4; i++) begin : g_btn
            logic          sync1_q;
            logic          sync2_q;
            logic          stable_q;
            logic          stable_d;
            logic [CW-1:0] cnt_q;
            logic [CW-1:0] cnt_d;

            always_ff @(posedge Clk or negedge Reset_n) begin
                if (!Reset_n) begin
                    sync1_q  <= 1'b0;
                    sync2_q  <= 1'b0;
                    stable_q <= 1'b0;
                    cnt_q    <= '0;
                end else begin
                    sync1_q  <= w_btn_raw[i];
                    sync2_q  <= sync1_q;
                    stable_q <= stable_d;
                    cnt_q    <= cnt_d;
                end
            end

            // Counter only runs while the input disagrees with the debounced level
            always_comb begin
                stable_d = stable_q;
                cnt_d    = '0;
                if (sync2_q != stable_q) begin
                    if (cnt_q == C_DB_LAST) begin
                        stable_d = sync2_q;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            assign w_stable[i] = stable_q;
        end
    endgenerate

    logic [3:0] btn_level_q;
    state_t     state_q;
    state_t     state_d;
    logic       press_pulse_q;
    logic       press_pulse_d;
    logic       multi_err_q;
    logic       multi_err_d;
    logic [2:0] press_code_q;
    logic [2:0] press_code_d;
    logic       w_one_hot;
    logic [2:0] w_enc;

    assign w_one_hot = ((btn_level_q & (btn_level_q - 4'd1)) == 4'd0);

    always_comb begin
        w_enc = 3'd0;
        case (btn_level_q)
            4'b0001: w_enc = 3'd1;
            4'b0010: w_enc = 3'd2;
            4'b0100: w_enc = 3'd3;
            4'b1000: w_enc = 3'd4;
            default: w_enc = 3'd0;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            btn_level_q   <= 4'd0;
            state_q       <= ST_IDLE;
            press_pulse_q <= 1'b0;
            multi_err_q   <= 1'b0;
            press_code_q  <= 3'd0;
        end else begin
            btn_level_q   <= w_stable;
            state_q       <= state_d;
            press_pulse_q <= press_pulse_d;
            multi_err_q   <= multi_err_d;
            press_code_q  <= press_code_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        press_pulse_d = 1'b0;
        multi_err_d   = 1'b0;
        press_code_d  = press_code_q;
        case (state_q)
            ST_IDLE: begin
                if (btn_level_q != 4'd0) begin
                    state_d = ST_HELD;
                    if (w_one_hot) begin
                        press_pulse_d = 1'b1;
                        press_code_d  = w_enc;
                    end else begin
                        multi_err_d = 1'b1;
                    end
                end
            end
            ST_HELD: begin
                if (btn_level_q == 4'd0) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A button already down at Clear must not turn into a fresh press
        if (Clear) begin
            press_code_d  = 3'd0;
            press_pulse_d = 1'b0;
            multi_err_d   = 1'b0;
            state_d       = any_held ? ST_HELD : ST_IDLE;
        end
    end

    assign press_pulse = press_pulse_q;
    assign multi_err   = multi_err_q;
    assign press_code  = press_code_q;
    assign btn_level   = btn_level_q;
    assign any_held    = |btn_level_q;

endmodule

`default_nettype wire
